// File: rtl/dlsc_stereobm_subpixel_sched_pkg.sv
// Shared definitions for the stereo block-matcher sub-pixel scheduler.
// Holds the lane packing helper, the lane-ID width check and the assertion
// messages used by the scheduler and its output FIFO.
package dlsc_stereobm_subpixel_sched_pkg;

  // LSB position of lane `lane` inside a packed bus of `width`-bit fields.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // A lane ID must be able to name every requester.
  function automatic bit id_bits_ok(input int requesters, input int id_bits);
    return (2 ** id_bits) >= requesters;
  endfunction

  localparam string MSG_ID_BITS       = "stereobm_subpixel_sched: ID_BITS too small for REQUESTERS";
  localparam string MSG_FIFO_OVERFLOW = "stereobm_subpixel_sched: result FIFO overflow (credit accounting broken)";
  localparam string MSG_CNT_OVERFLOW  = "stereobm_subpixel_sched: credit counter above FIFO_DEPTH";

endpackage

// File: rtl/dlsc_stereobm_subpixel_sched_fifo.sv
// Synchronous FIFO with a registered output word (first-word latency 1).
// Storage is an inferred RAM of DEPTH entries plus one output register; a
// push into a completely empty FIFO bypasses the RAM straight into the
// output register so the word is visible the cycle after the push.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_en_i       push (never refused; overflow is a fatal assertion)
//   wr_data_i     push data
//   rd_ready_i    consumer ready
//   rd_valid_o    output word valid
//   rd_data_o     output word, stable while rd_valid_o & !rd_ready_i
module dlsc_stereobm_subpixel_sched_fifo
  import dlsc_stereobm_subpixel_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0] mem_cnt_q;
  logic                out_valid_q;
  logic [WIDTH-1:0]    out_data_q;

  logic out_free, mem_rd, mem_wr, bypass, overflow;

  always_comb begin
    out_free = !out_valid_q || rd_ready_i;
    mem_rd   = out_free && (mem_cnt_q != '0);
    bypass   = out_free && (mem_cnt_q == '0) && wr_en_i;
    mem_wr   = wr_en_i && !bypass;
    overflow = mem_wr && !mem_rd && (mem_cnt_q == CNT_BITS'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (mem_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (mem_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({mem_wr, mem_rd})
        2'b10:   mem_cnt_q <= mem_cnt_q + 1'b1;
        2'b01:   mem_cnt_q <= mem_cnt_q - 1'b1;
        default: mem_cnt_q <= mem_cnt_q;
      endcase
      // Output register only changes once the current word has been taken.
      if (out_free) begin
        out_valid_q <= mem_rd || bypass;
        if (mem_rd) begin
          out_data_q <= mem[rd_ptr_q];
        end else if (bypass) begin
          out_data_q <= wr_data_i;
        end
      end
    end
  end

  assign rd_valid_o = out_valid_q;
  assign rd_data_o  = out_data_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !overflow)
    else $fatal(1, MSG_FIFO_OVERFLOW);

endmodule

// File: rtl/dlsc_stereobm_subpixel_sched.sv
// Shares one fixed-latency, non-stallable sub-pixel refinement unit between
// REQUESTERS disparity lanes. Requests are granted round-robin, registered
// onto the sp_* inputs of the shared unit, tagged with the lane ID through a
// tag pipe matching the unit latency, and collected in an output FIFO.
// A credit counter covers in-flight items plus FIFO occupancy so a result
// always has a slot waiting for it, regardless of out_ready.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready               per-lane handshake (in_ready one-hot or 0)
//   in_disp/in_sad/in_lo/in_hi      packed lane operands
//   sp_disp/sp_sad/sp_lo/sp_hi      registered operands to the shared unit
//   sp_out_disp                     shared-unit result, SP_LATENCY after sp_*
//   out_valid/out_ready             result handshake
//   out_id/out_disp                 originating lane and refined disparity
module dlsc_stereobm_subpixel_sched
  import dlsc_stereobm_subpixel_sched_pkg::*;
#(
  parameter int REQUESTERS  = 4,
  parameter int ID_BITS     = 2,
  parameter int DISP_BITS   = 6,
  parameter int SUB_BITS    = 4,
  parameter int SAD_BITS    = 16,
  parameter int SP_LATENCY  = 11,
  parameter int FIFO_DEPTH  = 16,
  parameter int DISP_BITS_S = DISP_BITS + SUB_BITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQUESTERS-1:0]          in_valid,
  output logic [REQUESTERS-1:0]          in_ready,
  input  logic [REQUESTERS*DISP_BITS-1:0] in_disp,
  input  logic [REQUESTERS*SAD_BITS-1:0] in_sad,
  input  logic [REQUESTERS*SAD_BITS-1:0] in_lo,
  input  logic [REQUESTERS*SAD_BITS-1:0] in_hi,
  output logic [DISP_BITS-1:0]           sp_disp,
  output logic [SAD_BITS-1:0]            sp_sad,
  output logic [SAD_BITS-1:0]            sp_lo,
  output logic [SAD_BITS-1:0]            sp_hi,
  input  logic [DISP_BITS_S-1:0]         sp_out_disp,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [ID_BITS-1:0]             out_id,
  output logic [DISP_BITS_S-1:0]         out_disp
);

  localparam int  CNT_BITS   = $clog2(FIFO_DEPTH + 1);
  localparam bit  ID_BITS_OK = id_bits_ok(REQUESTERS, ID_BITS);

  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [ID_BITS-1:0]  rr_ptr_q;
  logic [ID_BITS-1:0]  grant;
  logic                grant_found, credit_ok, accept, pop;

  // Round-robin search starting just after the last accepted lane.
  always_comb begin
    int idx;
    logic [ID_BITS-1:0] cand;
    idx         = 0;
    cand        = '0;
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      cand = ID_BITS'(idx);
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  // No same-cycle pop bypass: keeps in_ready off the out_ready path.
  assign credit_ok = cnt_q < CNT_BITS'(FIFO_DEPTH);
  assign accept    = !rst && grant_found && credit_ok;
  assign pop       = out_valid && out_ready;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  always_comb begin
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rr_ptr_q <= ID_BITS'(REQUESTERS - 1);
    end else begin
      cnt_q <= cnt_d;
      if (accept) rr_ptr_q <= grant;
    end
  end

  // Issue stage: operands of the granted lane, held while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_disp <= '0;
      sp_sad  <= '0;
      sp_lo   <= '0;
      sp_hi   <= '0;
    end else if (accept) begin
      sp_disp <= in_disp[lane_lsb(int'(grant), DISP_BITS) +: DISP_BITS];
      sp_sad  <= in_sad [lane_lsb(int'(grant), SAD_BITS)  +: SAD_BITS];
      sp_lo   <= in_lo  [lane_lsb(int'(grant), SAD_BITS)  +: SAD_BITS];
      sp_hi   <= in_hi  [lane_lsb(int'(grant), SAD_BITS)  +: SAD_BITS];
    end
  end

  // Tag pipe: stage k is valid at T+1+k, so stage SP_LATENCY lines up with
  // sp_out_disp. Valid bits are reset; IDs are plain shift registers.
  logic [SP_LATENCY:0] tag_valid_q;
  logic [ID_BITS-1:0]  tag_id_q [SP_LATENCY+1];

  generate
    for (genvar gi = 0; gi <= SP_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) tag_valid_q[gi] <= 1'b0;
          else     tag_valid_q[gi] <= accept;
        end
        always_ff @(posedge clk) tag_id_q[gi] <= grant;
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (rst) tag_valid_q[gi] <= 1'b0;
          else     tag_valid_q[gi] <= tag_valid_q[gi-1];
        end
        always_ff @(posedge clk) tag_id_q[gi] <= tag_id_q[gi-1];
      end
    end
  endgenerate

  dlsc_stereobm_subpixel_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ID_BITS + DISP_BITS_S)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (tag_valid_q[SP_LATENCY]),
    .wr_data_i  ({tag_id_q[SP_LATENCY], sp_out_disp}),
    .rd_ready_i (out_ready),
    .rd_valid_o (out_valid),
    .rd_data_o  ({out_id, out_disp})
  );

  a_id_bits: assert property (@(posedge clk) ID_BITS_OK)
    else $fatal(1, MSG_ID_BITS);
  a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_BITS'(FIFO_DEPTH))
    else $fatal(1, MSG_CNT_OVERFLOW);

endmodule

// File: doc/dlsc_stereobm_subpixel_sched.md
Name: dlsc_stereobm_subpixel_sched

Overview:
- Shares one fixed-latency sub-pixel refinement unit between REQUESTERS disparity-buffer lanes (multi-row stereo pipeline).
- Arbitrates lane requests round-robin and drives the shared unit's inputs with a registered stage.
- Tracks lane IDs alongside the unit's pipeline and collects results in an output FIFO.
- Uses credits so the non-stallable unit never overflows the FIFO under output backpressure.

Parameters:
- REQUESTERS, 4, number of requesting lanes (>=2)
- ID_BITS, 2, lane ID width; must satisfy 2**ID_BITS >= REQUESTERS
- DISP_BITS, 6, integer disparity width
- SUB_BITS, 4, fractional disparity bits produced by the shared unit
- SAD_BITS, 16, SAD width
- SP_LATENCY, 11, cycles from sp_* inputs to matching sp_out_disp; must be >=1
- FIFO_DEPTH, 16, output FIFO entries; power of 2, >=2
- DISP_BITS_S, DISP_BITS+SUB_BITS, derived; don't touch

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  REQUESTERS  per-lane request valid
- in_ready  out  REQUESTERS  per-lane accept; one-hot or zero
- in_disp  in  REQUESTERS*DISP_BITS  packed lane disparities; lane i at [i*DISP_BITS +: DISP_BITS]
- in_sad  in  REQUESTERS*SAD_BITS  packed best SAD
- in_lo  in  REQUESTERS*SAD_BITS  packed SAD at disp-1
- in_hi  in  REQUESTERS*SAD_BITS  packed SAD at disp+1
- sp_disp  out  DISP_BITS  to shared unit
- sp_sad  out  SAD_BITS  to shared unit
- sp_lo  out  SAD_BITS  to shared unit
- sp_hi  out  SAD_BITS  to shared unit
- sp_out_disp  in  DISP_BITS_S  result from shared unit
- out_ready  in  1  downstream ready
- out_valid  out  1  result valid
- out_id  out  ID_BITS  originating lane
- out_disp  out  DISP_BITS_S  refined disparity

Behaviour:
- Credit counter `cnt` (0..FIFO_DEPTH) counts in-flight items plus FIFO occupancy.
  - +1 on accept; -1 on pop (out_valid & out_ready); both in the same cycle leave it unchanged.
  - Credit OK when cnt < FIFO_DEPTH, using the registered cnt with no same-cycle pop bypass.
- Arbitration (combinational):
  - The grant goes to the first lane with in_valid set, searching cyclically from rr_ptr+1.
  - in_ready[g] = credit_ok for the granted lane only; all other in_ready bits are 0.
  - in_ready may depend on in_valid; in_valid must not depend on in_ready.
  - Accept = in_valid[g] & in_ready[g]. On accept, rr_ptr <= g; otherwise rr_ptr holds.
  - A lane that holds in_valid is served within REQUESTERS accepts.
- Issue stage: on accept cycle T, the lane's disp/sad/lo/hi are registered onto sp_* (valid at T+1).
  - sp_* hold their last value when idle. The shared unit ignores validity.
- Tag pipe:
  - SP_LATENCY+1 stages carry {valid, id}, entered at T. Stage SP_LATENCY aligns with sp_out_disp at T+1+SP_LATENCY.
  - When the tag is valid, {id, sp_out_disp} is pushed into the FIFO.
  - Push is never refused; credits guarantee space. An overflow is a fatal assertion.
- FIFO:
  - Registered output; first-word latency 1, so out_valid is earliest at T+2+SP_LATENCY.
  - Order is preserved: outputs appear in accept order.
  - out_id/out_disp are stable while out_valid & !out_ready.
  - Empty: out_valid=0. Full: no accept possible.
  - Pointers wrap modulo FIFO_DEPTH.
- Throughput: 1 accept/cycle is sustained with out_ready=1 when FIFO_DEPTH >= SP_LATENCY+3. Smaller depths are legal but rate-limited.
- Reset (any cycle, including mid-operation):
  - cnt=0, rr_ptr=REQUESTERS-1 (lane 0 has first priority), all tag valids=0, FIFO empty.
  - Outputs: out_valid=0, in_ready=0 during rst, sp_*=0, out_id=0, out_disp=0.
  - In-flight results are discarded; shared-unit results emerging after reset never reach the FIFO.

Decomposition:
- Shared stereobm package/include holds: lane packing helper (index math), ID width check, and assertion messages.
- One natural sub-module: the FIFO, reusing dlsc_fifo (synchronous, registered output, depth FIFO_DEPTH, width ID_BITS+DISP_BITS_S).
- The tag pipe stays inline: no-shreg registers for the valid bits, shift-register-eligible for the IDs.

Test Plan:
- Single request, lane 2: disp=10, sad=100, lo=200, hi=300 at T, shared-unit model returns 0xA5 -> sp_* = (10,100,200,300) at T+1; out_valid with out_id=2, out_disp=0xA5 at T+13 (SP_LATENCY=11).
- All 4 lanes valid continuously, out_ready=1 -> grants 0,1,2,3,0,1,... one per cycle; out_id follows the same sequence; no bubbles after fill.
- out_ready=0, lanes 0 and 1 streaming -> exactly 16 accepts, then in_ready=0; cnt=16. Raise out_ready -> 16 results drain in order with no loss or duplication, and accepts resume.
- cnt=15 with a simultaneous accept and pop -> cnt stays 15; the next cycle's accept is allowed. With cnt=16 and a pop-only cycle, an accept occurs the following cycle only.
- 5 items in flight, rst pulsed 1 cycle -> after release out_valid=0 for 20 cycles; in_ready low during rst; the first new request is granted to lane 0 when lanes 0 and 3 are both valid.
- Lane 3 held valid while lanes 0–2 saturate -> lane 3 is accepted within 4 accepts, with bounded wait every round.
